bus_mux_pipe: RTL and testbench

BUS_MUX_PIPE -- requirements
Module: bus_mux_pipe

---
 rtl/bus_mux_pipe.sv | 144 ++++++++++++++
 tb/tb_bus_mux_pipe.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_mux_pipe.sv
// -----------------------------------------------------------------------------
// bus_mux_pipe
//
// Registered shared-bus multiplexer. Each cycle the lowest-indexed requesting
// source wins the bus. Its data and index are captured into the output
// registers, so the latency from input to output is exactly one cycle. Cycles
// with more than one requester are flagged as conflicts and counted.
//
// Parameters
//   WIDTH     : width of each source and of the bus
//   NSRC      : number of sources (2..32)
//   SELW      : width of the encoded select index (2**SELW >= NSRC)
//   HOLD_MODE : 1 = bus keeps its last value when idle, 0 = bus clears to zero
//
// Ports
//   clock           in   single clock, rising edge
//   clear_n         in   synchronous active-low reset, overrides all inputs
//   src_data        in   NSRC*WIDTH flattened sources, source i at [i*WIDTH +: WIDTH]
//   src_drive       in   NSRC drive requests, bit i = source i wants the bus
//   cnt_clear       in   zeroes conflict_cnt and conflict_sticky at next edge
//   bus_out         out  registered bus value
//   bus_valid       out  a source drove bus_out in the previous cycle
//   sel_idx         out  index of the source that last drove the bus
//   conflict        out  one-cycle flag, >1 request seen in the previous cycle
//   conflict_sticky out  set by any conflict, cleared by cnt_clear or reset
//   conflict_cnt    out  saturating 8-bit count of conflict cycles
// -----------------------------------------------------------------------------
module bus_mux_pipe #(
    parameter int WIDTH     = 32,
    parameter int NSRC      = 24,
    parameter int SELW      = 5,
    parameter int HOLD_MODE = 1
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic [NSRC-1:0]       src_drive,
    input  logic                  cnt_clear,
    output logic [WIDTH-1:0]      bus_out,
    output logic                  bus_valid,
    output logic [SELW-1:0]       sel_idx,
    output logic                  conflict,
    output logic                  conflict_sticky,
    output logic [7:0]            conflict_cnt
);

    // Unpacked view of the flattened source bus.
    logic [WIDTH-1:0] src_arr [NSRC];

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_unpack
            assign src_arr[gi] = src_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Winner selection.
    logic [SELW-1:0]  win_idx;
    logic [WIDTH-1:0] win_data;
    logic             any_drive;
    logic             multi_drive;

    // Scanning from the top index down lets the lowest set bit overwrite the
    // others, giving lowest-index priority without a separate encoder. Only
    // indices that exist are scanned, so win_idx never exceeds NSRC-1.
    always_comb begin
        win_idx  = '0;
        win_data = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (src_drive[i]) begin
                win_idx  = SELW'(i);
                win_data = src_arr[i];
            end
        end
    end

    assign any_drive = |src_drive;

    // Clearing the lowest set bit leaves something behind only when at least
    // two bits were set.
    assign multi_drive = |(src_drive & (src_drive - {{(NSRC-1){1'b0}}, 1'b1}));

    // Output registers.
    logic [WIDTH-1:0] bus_q,      bus_d;
    logic             valid_q,    valid_d;
    logic [SELW-1:0]  sel_q,      sel_d;
    logic             conflict_q, conflict_d;
    logic             sticky_q,   sticky_d;
    logic [7:0]       cnt_q,      cnt_d;

    always_comb begin
        bus_d      = bus_q;
        sel_d      = sel_q;
        valid_d    = any_drive;
        conflict_d = multi_drive;
        sticky_d   = sticky_q;
        cnt_d      = cnt_q;

        if (any_drive) begin
            bus_d = win_data;
            sel_d = win_idx;
        end else if (HOLD_MODE == 0) begin
            bus_d = '0;
        end

        // A clear on the same edge as a conflict wins over the count and the
        // sticky flag; the conflict pulse itself is unaffected.
        if (cnt_clear) begin
            sticky_d = 1'b0;
            cnt_d    = '0;
        end else if (multi_drive) begin
            sticky_d = 1'b1;
            if (cnt_q != 8'hFF) begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            bus_q      <= '0;
            valid_q    <= 1'b0;
            sel_q      <= '0;
            conflict_q <= 1'b0;
            sticky_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            bus_q      <= bus_d;
            valid_q    <= valid_d;
            sel_q      <= sel_d;
            conflict_q <= conflict_d;
            sticky_q   <= sticky_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus_out         = bus_q;
    assign bus_valid       = valid_q;
    assign sel_idx         = sel_q;
    assign conflict        = conflict_q;
    assign conflict_sticky = sticky_q;
    assign conflict_cnt    = cnt_q;

endmodule

// File: tb/tb_bus_mux_pipe.sv
// -----------------------------------------------------------------------------
// tb_bus_mux_pipe
//
// Scoreboard bench for bus_mux_pipe. Three instances are used:
//   dut_h : defaults, HOLD_MODE = 1
//   dut_z : defaults, HOLD_MODE = 0 (shares stimulus with dut_h)
//   dut_c : WIDTH = 8, NSRC = 4, SELW = 2
// The stimulus drives inputs on the falling edge and pushes the expected
// response for the following rising edge. Monitors pop and compare just after
// each rising edge.
// -----------------------------------------------------------------------------
module tb_bus_mux_pipe;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          clear_n   = 1'b0;
    logic [767:0]  src_data  = '0;
    logic [23:0]   src_drive = '0;
    logic          cnt_clear = 1'b0;

    logic [31:0] h_bus,  z_bus;
    logic        h_vld,  z_vld;
    logic [4:0]  h_sel,  z_sel;
    logic        h_cf,   z_cf;
    logic        h_st,   z_st;
    logic [7:0]  h_cnt,  z_cnt;

    logic [31:0] c_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    logic [3:0]  c_drive = '0;
    logic [7:0]  c_bus;
    logic        c_vld;
    logic [1:0]  c_sel;
    logic        c_cf,  c_st;
    logic [7:0]  c_cnt;

    bus_mux_pipe #(.WIDTH(32), .NSRC(24), .SELW(5), .HOLD_MODE(1)) dut_h (
        .clock(clock), .clear_n(clear_n), .src_data(src_data),
        .src_drive(src_drive), .cnt_clear(cnt_clear),
        .bus_out(h_bus), .bus_valid(h_vld), .sel_idx(h_sel),
        .conflict(h_cf), .conflict_sticky(h_st), .conflict_cnt(h_cnt)
    );

    bus_mux_pipe #(.WIDTH(32), .NSRC(24), .SELW(5), .HOLD_MODE(0)) dut_z (
        .clock(clock), .clear_n(clear_n), .src_data(src_data),
        .src_drive(src_drive), .cnt_clear(cnt_clear),
        .bus_out(z_bus), .bus_valid(z_vld), .sel_idx(z_sel),
        .conflict(z_cf), .conflict_sticky(z_st), .conflict_cnt(z_cnt)
    );

    bus_mux_pipe #(.WIDTH(8), .NSRC(4), .SELW(2), .HOLD_MODE(1)) dut_c (
        .clock(clock), .clear_n(clear_n), .src_data(c_data),
        .src_drive(c_drive), .cnt_clear(1'b0),
        .bus_out(c_bus), .bus_valid(c_vld), .sel_idx(c_sel),
        .conflict(c_cf), .conflict_sticky(c_st), .conflict_cnt(c_cnt)
    );

    typedef struct {
        logic [31:0] bus_h;
        logic [31:0] bus_z;
        logic        vld;
        logic [4:0]  sel;
        logic        cf;
        logic        st;
        logic [7:0]  cnt;
    } exp_t;

    typedef struct {
        logic [7:0] bus;
        logic [1:0] sel;
        logic       vld;
        logic       cf;
    } expc_t;

    exp_t  q_main [$];
    expc_t q_c    [$];

    int checks   = 0;
    int failures = 0;

    logic [31:0] src_arr [24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Main monitor: one line per transaction, then field comparisons.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q_main.size() > 0) begin
                e = q_main.pop_front();
                $display("main: bus_h=%h bus_z=%h vld=%0d sel=%0d cf=%0d st=%0d cnt=%0d",
                         h_bus, z_bus, h_vld, h_sel, h_cf, h_st, h_cnt);
                chk("h.bus_out",   h_bus,        e.bus_h);
                chk("h.bus_valid", 32'(h_vld),   32'(e.vld));
                chk("h.sel_idx",   32'(h_sel),   32'(e.sel));
                chk("h.conflict",  32'(h_cf),    32'(e.cf));
                chk("h.sticky",    32'(h_st),    32'(e.st));
                chk("h.cnt",       32'(h_cnt),   32'(e.cnt));
                chk("z.bus_out",   z_bus,        e.bus_z);
                chk("z.bus_valid", 32'(z_vld),   32'(e.vld));
                chk("z.sel_idx",   32'(z_sel),   32'(e.sel));
                chk("z.conflict",  32'(z_cf),    32'(e.cf));
                chk("z.cnt",       32'(z_cnt),   32'(e.cnt));
            end
        end
    end

    // Small-parameter monitor.
    initial begin
        expc_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q_c.size() > 0) begin
                e = q_c.pop_front();
                $display("small: bus=%h vld=%0d sel=%0d cf=%0d", c_bus, c_vld, c_sel, c_cf);
                chk("c.bus_out",   32'(c_bus), 32'(e.bus));
                chk("c.sel_idx",   32'(c_sel), 32'(e.sel));
                chk("c.bus_valid", 32'(c_vld), 32'(e.vld));
                chk("c.conflict",  32'(c_cf),  32'(e.cf));
            end
        end
    end

    task automatic step(input logic rstn, input logic [23:0] drv, input logic clr,
                        input logic [31:0] bh, input logic [31:0] bz, input logic v,
                        input logic [4:0] s, input logic cf, input logic st,
                        input logic [7:0] cnt);
        exp_t e;
        @(negedge clock);
        clear_n   = rstn;
        src_drive = drv;
        cnt_clear = clr;
        e.bus_h = bh;
        e.bus_z = bz;
        e.vld   = v;
        e.sel   = s;
        e.cf    = cf;
        e.st    = st;
        e.cnt   = cnt;
        q_main.push_back(e);
    endtask

    task automatic stepc(input logic [3:0] drv, input logic [7:0] b,
                         input logic [1:0] s, input logic v, input logic cf);
        expc_t e;
        @(negedge clock);
        c_drive = drv;
        e.bus = b;
        e.sel = s;
        e.vld = v;
        e.cf  = cf;
        q_c.push_back(e);
    endtask

    initial begin
        for (int i = 0; i < 24; i++) begin
            src_arr[i] = 32'hA500_0000 | 32'(i);
        end
        src_arr[1]  = 32'h1111_1111;
        src_arr[3]  = 32'h0000_0003;
        src_arr[5]  = 32'h0000_0055;
        src_arr[7]  = 32'h0000_0007;
        src_arr[21] = 32'hDEAD_BEEF;
        for (int i = 0; i < 24; i++) begin
            src_data[i*32 +: 32] = src_arr[i];
        end

        // Reset overrides drive and clear.
        step(1'b0, 24'hFFFFFF, 1'b1, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 8'd0);
        step(1'b0, 24'h000006, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 8'd0);

        // Single drive, first edge after reset release.
        step(1'b1, 24'h200000, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 5'd21, 1'b0, 1'b0, 8'd0);
        // Conflict: sources 3 and 7, lowest wins.
        step(1'b1, 24'h000088, 1'b0, 32'h3, 32'h3, 1'b1, 5'd3, 1'b1, 1'b1, 8'd1);
        // Drive source 5 then idle for three cycles.
        step(1'b1, 24'h000020, 1'b0, 32'h55, 32'h55, 1'b1, 5'd5, 1'b0, 1'b1, 8'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 24'h0, 1'b0, 32'h55, 32'h0, 1'b0, 5'd5, 1'b0, 1'b1, 8'd1);
        end
        // Clear while idle: bus/sel/valid untouched.
        step(1'b1, 24'h0, 1'b1, 32'h55, 32'h0, 1'b0, 5'd5, 1'b0, 1'b0, 8'd0);

        // 300 conflict cycles, count saturates at 255.
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 24'h00F000, 1'b0, src_arr[12], src_arr[12], 1'b1, 5'd12,
                 1'b1, 1'b1, (i >= 254) ? 8'd255 : 8'(i + 1));
        end
        // Clear coincident with conflict: clear wins, pulse still asserts.
        step(1'b1, 24'h800001, 1'b1, src_arr[0], src_arr[0], 1'b1, 5'd0, 1'b1, 1'b0, 8'd0);
        // Highest index alone.
        step(1'b1, 24'h800000, 1'b0, src_arr[23], src_arr[23], 1'b1, 5'd23, 1'b0, 1'b0, 8'd0);
        // Conflict on sources 1 and 2.
        step(1'b1, 24'h000006, 1'b0, src_arr[1], src_arr[1], 1'b1, 5'd1, 1'b1, 1'b1, 8'd1);
        // Reset mid-stream while source 1 drives.
        step(1'b0, 24'h000002, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 8'd0);
        step(1'b1, 24'h000002, 1'b0, src_arr[1], src_arr[1], 1'b1, 5'd1, 1'b0, 1'b0, 8'd0);
        step(1'b1, 24'h000000, 1'b0, src_arr[1], 32'h0, 1'b0, 5'd1, 1'b0, 1'b0, 8'd0);

        // Small-parameter instance: each source in turn, then conflicts and idle.
        stepc(4'b0001, 8'h11, 2'd0, 1'b1, 1'b0);
        stepc(4'b0010, 8'h22, 2'd1, 1'b1, 1'b0);
        stepc(4'b0100, 8'h33, 2'd2, 1'b1, 1'b0);
        stepc(4'b1000, 8'h44, 2'd3, 1'b1, 1'b0);
        stepc(4'b1100, 8'h33, 2'd2, 1'b1, 1'b1);
        stepc(4'b0000, 8'h33, 2'd2, 1'b0, 1'b0);
        stepc(4'b0011, 8'h11, 2'd0, 1'b1, 1'b1);

        repeat (3) @(negedge clock);
        chk("main.queue_drained", 32'(q_main.size()), 32'd0);
        chk("small.queue_drained", 32'(q_c.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
